// File: rtl/dense_output_layer.sv
`default_nettype none
// ============================================================================
// Module      : dense_output_layer
// Description : Fully-connected output stage y = act(W*h2 + b), signed fixed
//               point, one multiply-accumulate per cycle, start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module dense_output_layer #(
    parameter int INPUT_SIZE  = 32,
    parameter int OUTPUT_SIZE = 6,
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 12,
    parameter int RELU        = 0
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [INPUT_SIZE*DATA_WIDTH-1:0]          x,
    input  logic [OUTPUT_SIZE*INPUT_SIZE*DATA_WIDTH-1:0] W,
    input  logic [OUTPUT_SIZE*DATA_WIDTH-1:0]         b,
    output logic                                      busy,
    output logic                                      done,
    output logic [OUTPUT_SIZE*DATA_WIDTH-1:0]         y
);

    localparam int c_ACC_W = 2*DATA_WIDTH + $clog2(INPUT_SIZE+1) + 1;
    localparam int c_SUM_W = c_ACC_W + 1;
    localparam int c_PROD_W = 2*DATA_WIDTH;
    localparam int c_I_W   = (INPUT_SIZE  > 1) ? $clog2(INPUT_SIZE)  : 1;
    localparam int c_J_W   = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;

    localparam logic [c_I_W-1:0] c_I_LAST = c_I_W'(INPUT_SIZE-1);
    localparam logic [c_J_W-1:0] c_J_LAST = c_J_W'(OUTPUT_SIZE-1);

    localparam logic signed [c_SUM_W-1:0] c_HALF = c_SUM_W'(1) << (FRAC_BITS-1);
    localparam logic signed [c_SUM_W-1:0] c_MAX  = c_SUM_W'((1 << (DATA_WIDTH-1)) - 1);
    localparam logic signed [c_SUM_W-1:0] c_MIN  = ~c_MAX;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MAC  = 2'd1;
    localparam logic [1:0] c_BIAS = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]                      r_state;
    logic [1:0]                      w_state_next;
    logic [INPUT_SIZE*DATA_WIDTH-1:0] r_x_q;
    logic [c_I_W-1:0]                r_i;
    logic [c_J_W-1:0]                r_j;
    logic signed [c_ACC_W-1:0]       r_acc;
    logic [OUTPUT_SIZE*DATA_WIDTH-1:0] r_y;

    logic [31:0]                     w_w_idx;
    logic signed [DATA_WIDTH-1:0]    w_x_sel;
    logic signed [DATA_WIDTH-1:0]    w_w_sel;
    logic signed [DATA_WIDTH-1:0]    w_b_sel;
    logic signed [c_PROD_W-1:0]      w_prod;
    logic signed [c_ACC_W-1:0]       w_prod_ext;
    logic signed [c_SUM_W-1:0]       w_acc_ext;
    logic signed [c_SUM_W-1:0]       w_bias_ext;
    logic signed [c_SUM_W-1:0]       w_sum;
    logic signed [c_SUM_W-1:0]       w_shr;
    logic [DATA_WIDTH-1:0]           w_sat;
    logic [DATA_WIDTH-1:0]           w_res;

    // ---------------- operand selection and MAC ----------------
    assign w_w_idx    = 32'(r_j) * 32'(INPUT_SIZE) + 32'(r_i);
    assign w_x_sel    = r_x_q[32'(r_i)*DATA_WIDTH +: DATA_WIDTH];
    assign w_w_sel    = W[w_w_idx*DATA_WIDTH +: DATA_WIDTH];
    assign w_b_sel    = b[32'(r_j)*DATA_WIDTH +: DATA_WIDTH];
    assign w_prod     = w_x_sel * w_w_sel;
    assign w_prod_ext = {{(c_ACC_W-c_PROD_W){w_prod[c_PROD_W-1]}}, w_prod};

    // Bias is aligned to the product's 2*FRAC_BITS scale before rounding.
    assign w_acc_ext  = {r_acc[c_ACC_W-1], r_acc};
    assign w_bias_ext = {{(c_SUM_W-DATA_WIDTH){w_b_sel[DATA_WIDTH-1]}}, w_b_sel} <<< FRAC_BITS;
    assign w_sum      = w_acc_ext + w_bias_ext + c_HALF;
    assign w_shr      = w_sum >>> FRAC_BITS;

    always_comb begin
        w_sat = w_shr[DATA_WIDTH-1:0];
        if (w_shr > c_MAX) begin
            w_sat = c_MAX[DATA_WIDTH-1:0];
        end else if (w_shr < c_MIN) begin
            w_sat = c_MIN[DATA_WIDTH-1:0];
        end
        w_res = w_sat;
        if ((RELU != 0) && w_sat[DATA_WIDTH-1]) begin
            w_res = '0;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: if (start) w_state_next = c_MAC;
            c_MAC:  if (r_i == c_I_LAST) w_state_next = c_BIAS;
            c_BIAS: w_state_next = (r_j == c_J_LAST) ? c_DONE : c_MAC;
            c_DONE: w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (r_state != c_IDLE);
        done = (r_state == c_DONE);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_q <= '0;
            r_i   <= '0;
            r_j   <= '0;
            r_acc <= '0;
            r_y   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_x_q <= x;
                        r_acc <= '0;
                        r_i   <= '0;
                        r_j   <= '0;
                    end
                end
                c_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    if (r_i != c_I_LAST) begin
                        r_i <= r_i + 1'b1;
                    end
                end
                c_BIAS: begin
                    r_y[32'(r_j)*DATA_WIDTH +: DATA_WIDTH] <= w_res;
                    if (r_j != c_J_LAST) begin
                        r_j   <= r_j + 1'b1;
                        r_i   <= '0;
                        r_acc <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign y = r_y;

endmodule
`default_nettype wire

// File: tb/tb_dense_output_layer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dense_output_layer
// Description : Scoreboard bench for dense_output_layer (identity and ReLU
//               instances driven by the same directed vectors).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dense_output_layer;

    localparam int IS = 32;
    localparam int OS = 6;
    localparam int DW = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [IS*DW-1:0]      x;
    logic [OS*IS*DW-1:0]   W;
    logic [OS*DW-1:0]      b;
    logic                  busy0, done0, busy1, done1;
    logic [OS*DW-1:0]      y0, y1;

    always #5 clk = ~clk;

    dense_output_layer #(.INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .DATA_WIDTH(DW),
                         .FRAC_BITS(12), .RELU(0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .W(W), .b(b),
        .busy(busy0), .done(done0), .y(y0));

    dense_output_layer #(.INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .DATA_WIDTH(DW),
                         .FRAC_BITS(12), .RELU(1)) u_dut_relu (
        .clk(clk), .rst(rst), .start(start), .x(x), .W(W), .b(b),
        .busy(busy1), .done(done1), .y(y1));

    int n_checks = 0;
    int n_errors = 0;

    // Each entry: {expected y of RELU=1 instance, expected y of RELU=0 instance}
    logic [2*OS*DW-1:0] exp_q[$];
    logic [2*OS*DW-1:0] exp_e;
    logic               done_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [OS*DW-1:0] rep(input logic [DW-1:0] v);
        return {OS{v}};
    endfunction

    // Monitor: pops one expected vector per done pulse.
    always @(negedge clk) begin
        if (done0 || done1) begin
            check("done_relu0", {31'b0, done0}, 32'd1);
            check("done_relu1", {31'b0, done1}, 32'd1);
            check("done_width", {31'b0, done_prev}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done with empty scoreboard required none");
            end else begin
                exp_e = exp_q.pop_front();
                for (int j = 0; j < OS; j++) begin
                    check($sformatf("y%0d_relu0", j), {16'b0, y0[j*DW +: DW]}, {16'b0, exp_e[j*DW +: DW]});
                    check($sformatf("y%0d_relu1", j), {16'b0, y1[j*DW +: DW]}, {16'b0, exp_e[OS*DW + j*DW +: DW]});
                end
            end
        end
        done_prev <= done0;
    end

    task automatic run(input logic [2*OS*DW-1:0] e, input string name);
        int lat;
        bit seen;
        exp_q.push_back(e);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        lat = 1;
        seen = 1'b0;
        while (!seen && lat < 400) begin
            if (done0) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check({name, "_done_seen"}, {31'b0, seen}, 32'd1);
        check({name, "_latency"}, 32'(lat), 32'd199);
        @(negedge clk);
    endtask

    task automatic set_x_all(input logic [DW-1:0] v);
        for (int i = 0; i < IS; i++) x[i*DW +: DW] = v;
    endtask

    task automatic set_w_all(input logic [DW-1:0] v);
        for (int k = 0; k < OS*IS; k++) W[k*DW +: DW] = v;
    endtask

    task automatic set_w_diag();
        W = '0;
        for (int j = 0; j < OS; j++) W[(j*IS + j)*DW +: DW] = 16'h1000;
    endtask

    task automatic set_x_ramp();
        for (int i = 0; i < IS; i++) x[i*DW +: DW] = 16'(i*256);
    endtask

    logic [OS*DW-1:0] idv;

    initial begin
        int  lat;
        bit  seen;
        bit  any_done;

        rst = 1'b1; start = 1'b0; x = '0; W = '0; b = '0;
        for (int j = 0; j < OS; j++) idv[j*DW +: DW] = 16'(j*256);

        // Reset
        repeat (2) @(negedge clk);
        check("reset_y_relu0", 32'(y0 != '0), 32'd0);
        check("reset_y_relu1", 32'(y1 != '0), 32'd0);
        check("reset_done", {31'b0, done0}, 32'd0);
        check("reset_busy", {31'b0, busy0}, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_busy", {31'b0, busy0}, 32'd0);
        end

        // Identity weights: y[j] = x[j]
        set_x_ramp(); set_w_diag(); b = '0;
        run({idv, idv}, "identity");

        // Bias only
        W = '0; b = rep(16'h0800);
        run({rep(16'h0800), rep(16'h0800)}, "bias");

        // Half-LSB rounds up
        x = '0; x[DW-1:0] = 16'h0001; b = '0; W = '0;
        for (int j = 0; j < OS; j++) W[(j*IS)*DW +: DW] = 16'h0800;
        run({rep(16'h0001), rep(16'h0001)}, "round_pos");

        // -half rounds up to zero
        x[DW-1:0] = 16'hFFFF;
        run({rep(16'h0000), rep(16'h0000)}, "round_neg");

        // Positive saturation
        set_x_all(16'h7FFF); set_w_all(16'h7FFF); b = '0;
        run({rep(16'h7FFF), rep(16'h7FFF)}, "sat_pos");

        // Negative saturation, ReLU clamps to zero
        set_w_all(16'h8001);
        run({rep(16'h0000), rep(16'h8000)}, "sat_neg");

        // Handshake: x changes after acceptance, extra starts while busy and in DONE
        set_x_ramp(); set_w_diag(); b = '0;
        exp_q.push_back({idv, idv});
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        set_x_all(16'h0123);
        lat = 1; seen = 1'b0;
        while (!seen && lat < 400) begin
            if (done0) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
                if (lat == 50) start = 1'b1;
                else if (lat == 51) start = 1'b0;
            end
        end
        check("hs_done_seen", {31'b0, seen}, 32'd1);
        check("hs_latency", 32'(lat), 32'd199);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hs_no_retrigger", {31'b0, busy0}, 32'd0);
        end

        // Abort mid-run, then a clean rerun
        set_x_all(16'h1000); set_w_all(16'h0100); b = rep(16'h0100);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        lat = 1;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
        end
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("abort_y_relu0", 32'(y0 != '0), 32'd0);
        check("abort_y_relu1", 32'(y1 != '0), 32'd0);
        check("abort_busy", {31'b0, busy0}, 32'd0);
        any_done = 1'b0;
        for (int k = 0; k < 250; k++) begin
            @(negedge clk);
            if (done0 || done1) any_done = 1'b1;
        end
        check("abort_no_done", {31'b0, any_done}, 32'd0);
        run({rep(16'h2100), rep(16'h2100)}, "rerun");

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
